// File: rtl/acp_pp_pkg.sv
// Shared types and register map for the ACP ping-pong buffer controller.
// No logic; no latency; no backpressure.
package acp_pp_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_FILLING = 2'd1,
        SLOT_READY   = 2'd2
    } slot_state_e;

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_FCNT   = 3'd2;
    localparam logic [2:0] ADDR_DCNT   = 3'd3;
    localparam logic [2:0] ADDR_ACK    = 3'd4 + 3'd1;
    localparam logic [2:0] ADDR_IMSK   = 3'd6;

endpackage

// File: rtl/acp_pp_slot.sv
// Ownership FSM for one buffer: FREE -> FILLING -> READY -> FREE.
// State updates one cycle after grant/done/ack; no backpressure.
module acp_pp_slot
    import acp_pp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        grant,
    input  logic        done,
    input  logic        ack,
    output slot_state_e state,
    output logic        is_free,
    output logic        is_ready
);

    slot_state_e state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= SLOT_FREE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_FREE:    if (grant) state_d = SLOT_FILLING;
            SLOT_FILLING: if (done)  state_d = SLOT_READY;
            // An ack frees the slot in time for a same-cycle grant.
            SLOT_READY:   if (ack)   state_d = grant ? SLOT_FILLING : SLOT_FREE;
            default:                 state_d = SLOT_FREE;
        endcase
    end

    assign state    = state_q;
    assign is_free  = (state_q == SLOT_FREE);
    assign is_ready = (state_q == SLOT_READY);

endmodule

// File: rtl/acp_pp_buf_ctrl.sv
// Ping-pong BRAM buffer allocator with Avalon-MM status/ack registers; optional irq via ACP_PP_IRQ_EN.
// Grant visible one cycle after frame_sof; readdata one cycle after chipselect, zero wait states.
// No stall path: frames arriving with no free buffer are dropped and counted.
module acp_pp_buf_ctrl
    import acp_pp_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int BUF_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              frame_sof,
    input  logic              fill_done,
    output logic              fill_gnt,
    output logic              fill_sel,
    output logic [BUF_AW:0]   fill_base,
    output logic              irq
);

    logic             wr_en;
    logic [1:0]       ack_vec, free_eff, is_free, is_ready, grant_vec, done_vec;
    slot_state_e      slot_state [2];
    logic             grant_vld, grant_sel, drop_evt, done_evt;

    logic             fill_gnt_q, fill_gnt_d;
    logic             fill_sel_q, fill_sel_d;
    logic             last_q, last_d;
    logic             enable_q, enable_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]      rd_dat, readdata_q;

    assign wr_en    = chipselect & ~write_n;
    assign ack_vec  = (wr_en && address == ADDR_ACK) ? writedata[1:0] : 2'b00;
    assign free_eff = is_free | (is_ready & ack_vec);

    for (genvar n = 0; n < 2; n++) begin : g_slot
        acp_pp_slot u_slot (
            .clk      (clk),
            .reset    (reset),
            .grant    (grant_vec[n]),
            .done     (done_vec[n]),
            .ack      (ack_vec[n]),
            .state    (slot_state[n]),
            .is_free  (is_free[n]),
            .is_ready (is_ready[n])
        );
    end

    // Prefer the buffer not filled last so the HPS sees strict alternation.
    always_comb begin
        grant_vld = 1'b0;
        grant_sel = 1'b0;
        drop_evt  = 1'b0;
        if (frame_sof) begin
            if (fill_gnt_q || !enable_q) begin
                drop_evt = 1'b1;
            end else if (free_eff[~last_q]) begin
                grant_vld = 1'b1;
                grant_sel = ~last_q;
            end else if (free_eff[last_q]) begin
                grant_vld = 1'b1;
                grant_sel = last_q;
            end else begin
                drop_evt = 1'b1;
            end
        end
    end

    assign done_evt  = fill_done & fill_gnt_q;
    assign grant_vec = grant_vld ? (2'b01 << grant_sel) : 2'b00;
    assign done_vec  = done_evt ? (2'b01 << fill_sel_q) : 2'b00;

    always_comb begin
        fill_gnt_d  = fill_gnt_q;
        fill_sel_d  = fill_sel_q;
        last_d      = last_q;
        enable_d    = enable_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (done_evt) begin
            fill_gnt_d = 1'b0;
            last_d     = fill_sel_q;
            if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
        end
        if (grant_vld) begin
            fill_gnt_d = 1'b1;
            fill_sel_d = grant_sel;
        end
        if (wr_en && address == ADDR_CTRL) enable_d = writedata[0];
        if (wr_en && address == ADDR_DCNT)         drop_cnt_d = '0;
        else if (drop_evt && drop_cnt_q != '1)     drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_gnt_q  <= 1'b0;
            fill_sel_q  <= 1'b0;
            last_q      <= 1'b1;
            enable_q    <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            readdata_q  <= '0;
        end else begin
            fill_gnt_q  <= fill_gnt_d;
            fill_sel_q  <= fill_sel_d;
            last_q      <= last_d;
            enable_q    <= enable_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            readdata_q  <= chipselect ? rd_dat : 32'd0;
        end
    end

`ifdef ACP_PP_IRQ_EN
    logic [1:0] irq_mask_q, irq_mask_d;
    logic       irq_q;

    assign irq_mask_d = (wr_en && address == ADDR_IMSK) ? writedata[1:0] : irq_mask_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask_q <= 2'b00;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= |(is_ready & irq_mask_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_dat = 32'd0;
        case (address)
            ADDR_STATUS: begin
                rd_dat[1:0] = is_ready;
                rd_dat[2]   = fill_gnt_q;
                rd_dat[3]   = fill_sel_q;
                rd_dat[4]   = last_q;
                rd_dat[8]   = enable_q;
            end
            ADDR_CTRL: rd_dat[0] = enable_q;
            ADDR_FCNT: rd_dat[CNT_W-1:0] = frame_cnt_q;
            ADDR_DCNT: rd_dat[CNT_W-1:0] = drop_cnt_q;
`ifdef ACP_PP_IRQ_EN
            ADDR_IMSK: rd_dat[1:0] = irq_mask_q;
`endif
            default:   rd_dat = 32'd0;
        endcase
    end

    logic unused_ok;
    assign unused_ok = ^{writedata[31:2], slot_state[0], slot_state[1]};

    assign readdata  = readdata_q;
    assign fill_gnt  = fill_gnt_q;
    assign fill_sel  = fill_sel_q;
    assign fill_base = {fill_sel_q, {BUF_AW{1'b0}}};

endmodule
